// File: rtl/mul_core_pkg.sv
// Shared definitions for mul_core: FSM state encoding and result/accumulator geometry.
package mul_core_pkg;
  localparam int RESULT_W = 32;
  localparam int ACC_W    = 64;
  localparam int BYTES    = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    FIX  = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;
endpackage

// File: rtl/mul_core_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, 32 cycles after start.
module shift_add_mul
  import mul_core_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [RESULT_W-1:0] mcand,
  input  logic [RESULT_W-1:0] mplier,
  output logic [ACC_W-1:0]    product,
  output logic                done
);
  logic [ACC_W-1:0]    mcand_sh;
  logic [RESULT_W-1:0] mplier_sh;
  logic [4:0]          cnt;
  logic                running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_sh  <= '0;
      mplier_sh <= '0;
      product   <= '0;
      cnt       <= '0;
      running   <= 1'b0;
    end else if (start) begin
      mcand_sh  <= {{(ACC_W-RESULT_W){1'b0}}, mcand};
      mplier_sh <= mplier;
      product   <= '0;
      cnt       <= '0;
      running   <= 1'b1;
    end else if (running) begin
      if (mplier_sh[0]) product <= product + mcand_sh;
      mcand_sh  <= mcand_sh << 1;
      mplier_sh <= mplier_sh >> 1;
      cnt       <= cnt + 5'd1;
      if (cnt == 5'd31) running <= 1'b0;
    end
  end

  // High during the cycle whose closing edge folds in the last multiplier bit.
  assign done = running && (cnt == 5'd31);
endmodule

// File: rtl/mul_core.sv
// Signed 32x32 multiply core with byte-serial output, MSB byte first.
// Define MUL_CORE_SATURATE_EN to clamp the result to signed 32 bits instead of wrapping.
module mul_core
  import mul_core_pkg::*;
#(
  parameter int BYTE_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic        start_calc,
  output logic        core_busy,
  output logic [7:0]  out_pins,
  output logic        out_valid,
  output logic        out_last
);
  localparam logic [3:0] HOLD_LAST = 4'(BYTE_HOLD - 1);
  localparam logic [1:0] LAST_IDX  = 2'(BYTES - 1);
`ifdef MUL_CORE_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -64'sh0000_0000_8000_0000;
`endif

  state_t                    state;
  logic                      armed;
  logic                      res_neg;
  logic [RESULT_W-1:0]       res;
  logic [1:0]                byte_idx;
  logic [3:0]                hold_cnt;
  logic                      accept;
  logic                      mul_done;
  logic [ACC_W-1:0]          product;
  logic signed [ACC_W-1:0]   prod_s;
  logic [RESULT_W-1:0]       fixed_res;

  function automatic logic [RESULT_W-1:0] magnitude(input logic [RESULT_W-1:0] v);
    return v[RESULT_W-1] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [RESULT_W-1:0] reduce(input logic signed [ACC_W-1:0] p);
`ifdef MUL_CORE_SATURATE_EN
    if (p > SAT_MAX) return 32'h7FFF_FFFF;
    if (p < SAT_MIN) return 32'h8000_0000;
`endif
    return p[RESULT_W-1:0];
  endfunction

  function automatic logic [7:0] select_byte(input logic [RESULT_W-1:0] r, input logic [1:0] idx);
    return 8'(r >> (8 * (BYTES - 1 - int'(idx))));
  endfunction

  assign accept    = (state == IDLE) && armed && start_calc;
  assign prod_s    = res_neg ? -$signed(product) : $signed(product);
  assign fixed_res = reduce(prod_s);

  shift_add_mul u_engine (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .mcand   (magnitude(a0)),
    .mplier  (magnitude(a1)),
    .product (product),
    .done    (mul_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      armed     <= 1'b1;
      res_neg   <= 1'b0;
      res       <= '0;
      byte_idx  <= '0;
      hold_cnt  <= '0;
      core_busy <= 1'b0;
      out_pins  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            res_neg   <= a0[31] ^ a1[31];
            armed     <= 1'b0;
            core_busy <= 1'b1;
            state     <= MUL;
          end else if (!armed && !start_calc) begin
            armed <= 1'b1;
          end
        end
        MUL: if (mul_done) state <= FIX;
        FIX: begin
          res       <= fixed_res;
          out_pins  <= select_byte(fixed_res, 2'd0);
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          byte_idx  <= 2'd0;
          hold_cnt  <= 4'd0;
          state     <= OUT;
        end
        OUT: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= 4'd0;
            if (byte_idx == LAST_IDX) begin
              state     <= DONE;
              core_busy <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_pins  <= 8'h00;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              out_pins <= select_byte(res, byte_idx + 2'd1);
              out_last <= (byte_idx + 2'd1 == LAST_IDX);
            end
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        // armed stays clear so a start_calc still held from this run cannot relaunch.
        DONE: state <= IDLE;
        default: begin
          state     <= IDLE;
          core_busy <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_pins  <= 8'h00;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_core.sv
// Directed, table-driven bench for mul_core (BYTE_HOLD=1 and BYTE_HOLD=3 instances).
module tb_mul_core;
`ifdef MUL_CORE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a0_1 = '0, a1_1 = '0, a0_3 = '0, a1_3 = '0;
  logic        start_1 = 1'b0, start_3 = 1'b0;
  logic        busy_1, valid_1, last_1, busy_3, valid_3, last_3;
  logic [7:0]  pins_1, pins_3;

  mul_core #(.BYTE_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a0(a0_1), .a1(a1_1), .start_calc(start_1),
    .core_busy(busy_1), .out_pins(pins_1), .out_valid(valid_1), .out_last(last_1));

  mul_core #(.BYTE_HOLD(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .a0(a0_3), .a1(a1_3), .start_calc(start_3),
    .core_busy(busy_3), .out_pins(pins_3), .out_valid(valid_3), .out_last(last_3));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_wrap;
    logic [31:0] exp_sat;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Launch one operation on the BYTE_HOLD=1 instance and observe ncyc cycles after the accept edge.
  task automatic run1(input logic [31:0] a, input logic [31:0] b, input bit hold_start,
                      input int ncyc, output logic [31:0] res, output int nbytes,
                      output int first_cyc, output int low_cyc, output int last_cnt,
                      output int last_cyc, output int busy_cnt, output int busy_c1);
    res = '0; nbytes = 0; first_cyc = -1; low_cyc = -1;
    last_cnt = 0; last_cyc = -1; busy_cnt = 0; busy_c1 = 0;
    @(negedge clk);
    a0_1 = a; a1_1 = b; start_1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        busy_c1 = int'(busy_1);
        if (!hold_start) start_1 = 1'b0;
        a0_1 = $urandom; a1_1 = $urandom;
      end
      if (busy_1) busy_cnt++;
      else if (low_cyc < 0) low_cyc = k;
      if (valid_1) begin
        res = {res[23:0], pins_1};
        nbytes++;
        if (first_cyc < 0) first_cyc = k;
        if (last_1) begin last_cnt++; last_cyc = k; end
      end else if (last_1 || pins_1 != 8'h00) begin
        last_cnt += 100;
      end
    end
    start_1 = 1'b0;
  endtask

  task automatic check_run(input string tag, input logic [31:0] exp, input logic [31:0] res,
                           input int nbytes, input int first_cyc, input int low_cyc,
                           input int last_cnt, input int last_cyc, input int busy_cnt,
                           input int busy_c1);
    check({tag, " result"}, res, exp);
    check({tag, " nbytes"}, nbytes, 4);
    check({tag, " first byte cycle"}, first_cyc, 34);
    check({tag, " busy low cycle"}, low_cyc, 38);
    check({tag, " last count/cycle"}, {last_cnt[31:0], last_cyc[31:0]}, {32'd1, 32'd37});
    check({tag, " busy cycles"}, {busy_c1[31:0], busy_cnt[31:0]}, {32'd1, 32'd37});
  endtask

  logic [31:0] res, exp;
  int nbytes, first_cyc, low_cyc, last_cnt, last_cyc, busy_cnt, busy_c1;
  int vcnt, bcnt;
  logic [7:0] pins_at [0:50];
  logic       valid_at[0:50];
  logic       last_at [0:50];
  logic       busy_at [0:50];

  initial begin
    vecs[0] = '{32'd3,          32'd5,          32'h0000_000F, 32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFE,  32'd7,          32'hFFFF_FFF2, 32'hFFFF_FFF2};
    vecs[2] = '{32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE, 32'h7FFF_FFFF};
    vecs[3] = '{32'd0,          32'h1234_5678,  32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'h7FFF_FFFF};
    vecs[5] = '{32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 32'h7FFF_FFFF};
    vecs[6] = '{32'hFFFF_FFFD,  32'hFFFF_FFFC,  32'h0000_000C, 32'h0000_000C};
    vecs[7] = '{32'h0001_2345,  32'hFFFF_FF00,  32'hFEDC_BB00, 32'hFEDC_BB00};
    vecs[8] = '{32'hFFFF_0000,  32'h0001_0000,  32'h0000_0000, 32'h8000_0000};

    repeat (3) @(negedge clk);
    check("reset dut1 outputs", {busy_1, valid_1, last_1, pins_1}, 11'd0);
    check("reset dut3 outputs", {busy_3, valid_3, last_3, pins_3}, 11'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      exp = SAT ? vecs[i].exp_sat : vecs[i].exp_wrap;
      run1(vecs[i].a, vecs[i].b, 1'b0, 45, res, nbytes, first_cyc, low_cyc,
           last_cnt, last_cyc, busy_cnt, busy_c1);
      check_run($sformatf("vec%0d", i), exp, res, nbytes, first_cyc, low_cyc,
                last_cnt, last_cyc, busy_cnt, busy_c1);
    end

    // start_calc held through completion and 10 more cycles: only one result.
    run1(32'd3, 32'd5, 1'b1, 48, res, nbytes, first_cyc, low_cyc,
         last_cnt, last_cyc, busy_cnt, busy_c1);
    check_run("held", 32'h0000_000F, res, nbytes, first_cyc, low_cyc,
              last_cnt, last_cyc, busy_cnt, busy_c1);
    run1(32'd6, 32'd7, 1'b0, 45, res, nbytes, first_cyc, low_cyc,
         last_cnt, last_cyc, busy_cnt, busy_c1);
    check_run("rearm", 32'd42, res, nbytes, first_cyc, low_cyc,
              last_cnt, last_cyc, busy_cnt, busy_c1);

    // Reset mid-MUL: outputs clear at once, nothing emitted, next run is clean.
    @(negedge clk);
    a0_1 = 32'd100; a1_1 = 32'hFFFF_FFFD; start_1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start_1 = 1'b0;
    end
    check("busy before abort", busy_1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort outputs", {busy_1, valid_1, last_1, pins_1}, 11'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0; bcnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (valid_1 || last_1 || pins_1 != 8'h00) vcnt++;
      if (busy_1) bcnt++;
    end
    check("post-abort quiet", {vcnt[31:0], bcnt[31:0]}, 64'd0);
    run1(32'd100, 32'hFFFF_FFFD, 1'b0, 45, res, nbytes, first_cyc, low_cyc,
         last_cnt, last_cyc, busy_cnt, busy_c1);
    check_run("after abort", 32'hFFFF_FED4, res, nbytes, first_cyc, low_cyc,
              last_cnt, last_cyc, busy_cnt, busy_c1);

    // BYTE_HOLD=3: each byte held for three cycles.
    exp = SAT ? 32'h7FFF_FFFF : 32'h8000_0000;
    @(negedge clk);
    a0_3 = 32'h8000_0000; a1_3 = 32'hFFFF_FFFF; start_3 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) begin start_3 = 1'b0; a0_3 = 32'd1; a1_3 = 32'd1; end
      pins_at[k] = pins_3; valid_at[k] = valid_3; last_at[k] = last_3; busy_at[k] = busy_3;
    end
    check("hold3 busy c1/c45/c46", {busy_at[1], busy_at[45], busy_at[46]}, 3'b110);
    check("hold3 idle edges", {valid_at[33], valid_at[46], pins_at[33], pins_at[46]}, 18'd0);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("hold3 byte c%0d", 34 + i), {valid_at[34+i], last_at[34+i], pins_at[34+i]},
            {1'b1, (i >= 9), 8'(exp >> (24 - 8 * (i / 3)))});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
